// File: rtl/boxcar_pkg.sv
// Shared types and helpers for the multi-channel boxcar decimator.
package boxcar_pkg;

    typedef enum logic {FILL, RUN} state_t;

    // Width needed to hold a window length or a full-window sum.
    function automatic int win_width(input int max_window);
        return $clog2(max_window + 1);
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] sum, input int res);
        logic [32:0] lim;
        lim = (33'd1 << res) - 33'd1;
        return ({1'b0, sum} > lim) ? lim[31:0] : sum;
    endfunction

endpackage

// File: rtl/boxcar_channel.sv
// One channel: history shift register, tap on the oldest in-window sample,
// running sum and saturated output register.
module boxcar_channel
    import boxcar_pkg::*;
#(
    parameter int MAX_WINDOW = 128,
    parameter int RESOLUTION = 6,
    parameter int WIN_W      = 8,
    parameter int TAP_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  fire,
    input  logic                  din,
    input  logic [TAP_W-1:0]      tap,
    output logic [RESOLUTION-1:0] value,
    output logic                  sat
);

    logic [MAX_WINDOW-1:0] hist;
    logic [WIN_W-1:0]      sum;
    logic [WIN_W-1:0]      sum_nxt;
    logic [31:0]           sum_sat;

    // The sum always equals popcount(hist[weff-1:0]), so it cannot underflow.
    always_comb begin
        sum_nxt = sum + WIN_W'(din) - WIN_W'(hist[tap]);
        sum_sat = saturate(32'(sum_nxt), RESOLUTION);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            sum   <= '0;
            value <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            hist <= '0;
            sum  <= '0;
        end else if (en) begin
            hist <= (hist << 1) | MAX_WINDOW'(din);
            sum  <= sum_nxt;
            if (fire) begin
                value <= sum_sat[RESOLUTION-1:0];
                sat   <= (32'(sum_nxt) != sum_sat);
            end
        end
    end

endmodule

// File: rtl/boxcar_decimator.sv
// Multi-channel 1-bit moving-sum decimator: shared fill/decimation control
// driving CHANNELS independent boxcar channels.
module boxcar_decimator
    import boxcar_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int MAX_WINDOW = 128,
    parameter int RESOLUTION = 6,
    parameter int DECIM_W    = 8,
    parameter int WIN_W      = win_width(MAX_WINDOW)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ce,
    input  logic [CHANNELS-1:0]            stream,
    input  logic [WIN_W-1:0]               window,
    input  logic [DECIM_W-1:0]             decim,
    input  logic                           restart,
    output logic [CHANNELS*RESOLUTION-1:0] value,
    output logic                           valid,
    output logic [CHANNELS-1:0]            sat,
    output logic                           filled
);

    localparam int TAP_W = (MAX_WINDOW > 1) ? $clog2(MAX_WINDOW) : 1;

    state_t             state;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   count;
    logic [DECIM_W-1:0] decim_cnt;

    logic [WIN_W-1:0]   weff;
    logic [DECIM_W-1:0] deff_m1;
    logic [TAP_W-1:0]   tap;
    logic               restart_cond;
    logic               accept;
    logic               fire;

    always_comb begin
        if (window == '0)
            weff = WIN_W'(1);
        else if (window > WIN_W'(MAX_WINDOW))
            weff = WIN_W'(MAX_WINDOW);
        else
            weff = window;
        tap          = TAP_W'(weff - WIN_W'(1));
        deff_m1      = (decim == '0) ? '0 : decim - DECIM_W'(1);
        // Any window change flushes history so the sum stays consistent.
        restart_cond = restart | (window != win_q);
        accept       = ce & ~restart_cond;
        fire         = 1'b0;
        if (accept) begin
            if (state == FILL)
                fire = (count == weff - WIN_W'(1));
            else
                fire = (decim_cnt >= deff_m1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            win_q     <= '0;
            count     <= '0;
            decim_cnt <= '0;
            valid     <= 1'b0;
            filled    <= 1'b0;
        end else begin
            win_q <= window;
            valid <= fire;
            if (restart_cond) begin
                state     <= FILL;
                count     <= '0;
                decim_cnt <= '0;
                filled    <= 1'b0;
            end else if (accept) begin
                case (state)
                    FILL: begin
                        if (fire) begin
                            state     <= RUN;
                            filled    <= 1'b1;
                            count     <= '0;
                            decim_cnt <= '0;
                        end else begin
                            count <= count + WIN_W'(1);
                        end
                    end
                    RUN: begin
                        if (fire)
                            decim_cnt <= '0;
                        else
                            decim_cnt <= decim_cnt + DECIM_W'(1);
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        boxcar_channel #(
            .MAX_WINDOW (MAX_WINDOW),
            .RESOLUTION (RESOLUTION),
            .WIN_W      (WIN_W),
            .TAP_W      (TAP_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .clear (restart_cond),
            .en    (ce),
            .fire  (fire),
            .din   (stream[c]),
            .tap   (tap),
            .value (value[c*RESOLUTION +: RESOLUTION]),
            .sat   (sat[c])
        );
    end

endmodule
